// File: rtl/reg_write_arbiter_if.sv
// Request/acknowledge bundle between the requesters and the shared-register
// write arbiter. The requesters drive the master side and the arbiter uses
// the slave side.
interface reg_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_WIDTH  = 2
) ();
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic [DATA_WIDTH-1:0]         data_out;
  logic [IDX_WIDTH-1:0]          owner;
  logic                          valid;
  logic                          busy;

  modport master (
    output req, req_data,
    input  ack, data_out, owner, valid, busy
  );

  modport slave (
    input  req, req_data,
    output ack, data_out, owner, valid, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of a shared holding register.
// Each write takes three cycles: IDLE (arbitrate), WRITE (sample the winner's
// word) and ACK (the new word and a one-cycle ack are visible).
module reg_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_WIDTH  = 2
) (
  input logic                 clk,
  input logic                 reset,
  reg_write_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [IDX_WIDTH-1:0]    grant_idx_reg;
  logic [IDX_WIDTH-1:0]    rr_ptr_reg;
  logic [IDX_WIDTH-1:0]    rr_ptr_next;
  logic [IDX_WIDTH-1:0]    winner;
  logic [IDX_WIDTH:0]      cand;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [IDX_WIDTH-1:0]    owner_reg;
  logic                    valid_reg;
  logic [NUM_REQ-1:0]      ack_reg;
  logic [NUM_REQ-1:0]      grant_onehot;
  logic [DATA_WIDTH-1:0]   word [NUM_REQ];

  // Unpack the request words and decode the registered winner to one-hot.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign word[gi]         = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign grant_onehot[gi] = (grant_idx_reg == IDX_WIDTH'(gi));
    end
  endgenerate

  // Round-robin search: walk from the farthest candidate back to rr_ptr so
  // the nearest requester at or after the pointer wins.
  always_comb begin
    winner = rr_ptr_reg;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (IDX_WIDTH+1)'(k);
      if (cand >= (IDX_WIDTH+1)'(NUM_REQ)) begin
        cand = cand - (IDX_WIDTH+1)'(NUM_REQ);
      end
      if (bus.req[cand[IDX_WIDTH-1:0]]) begin
        winner = cand[IDX_WIDTH-1:0];
      end
    end
  end

  // Pointer moves to the requester just after the one being served.
  always_comb begin
    rr_ptr_next = grant_idx_reg + IDX_WIDTH'(1);
    if (grant_idx_reg == IDX_WIDTH'(NUM_REQ - 1)) begin
      rr_ptr_next = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a WRITE always completes once entered, and ACK never
  // arbitrates, so a held request is only seen again back in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|bus.req) state_next = WRITE;
      WRITE:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant latch, held register, owner/valid, ack pulse and pointer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
      data_reg      <= '0;
      owner_reg     <= '0;
      valid_reg     <= 1'b0;
      ack_reg       <= '0;
    end else begin
      ack_reg <= '0;
      if (state_reg == IDLE && |bus.req) begin
        grant_idx_reg <= winner;
      end
      if (state_reg == WRITE) begin
        data_reg   <= word[grant_idx_reg];
        owner_reg  <= grant_idx_reg;
        valid_reg  <= 1'b1;
        ack_reg    <= grant_onehot;
        rr_ptr_reg <= rr_ptr_next;
      end
    end
  end

  assign bus.ack      = ack_reg;
  assign bus.data_out = data_reg;
  assign bus.owner    = owner_reg;
  assign bus.valid    = valid_reg;
  assign bus.busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for the round-robin shared-register write arbiter.
module tb_reg_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  logic [DW-1:0] words [NR];

  reg_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

  reg_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s value=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_words();
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = words[i];
  endtask

  // Wait a bounded number of cycles for an ack, then check the completed write.
  task automatic expect_grant(input string tag, input int idx, input logic [63:0] exp_data,
                              output int ack_cyc);
    logic found;
    logic [NR-1:0] exp_ack;
    found = 1'b0;
    ack_cyc = -1;
    for (int n = 0; n < 8 && !found; n++) begin
      tick();
      if (bus.ack != '0) found = 1'b1;
    end
    exp_ack = NR'(1) << idx;
    if (!found) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      ack_cyc = cyc;
      check({tag, "_ack"},   64'(bus.ack), 64'(exp_ack));
      check({tag, "_data"},  bus.data_out, exp_data);
      check({tag, "_owner"}, 64'(bus.owner), 64'(idx));
      check({tag, "_valid"}, 64'(bus.valid), 64'd1);
    end
  endtask

  initial begin
    int last_cyc;
    int this_cyc;
    int order [5];
    checks = 0;
    failures = 0;
    cyc = 0;
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NR; i++) words[i] = {32'hCAFE0000 + 32'(i), 32'h12345670 + 32'(i)};
    bus.req = '0;
    bus.req_data = '0;
    rst_n = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) tick();
    check("rst_data",  bus.data_out, 64'd0);
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_ack",   64'(bus.ack), 64'd0);
    check("rst_owner", 64'(bus.owner), 64'd0);
    rst_n = 1'b1;

    // Single request from requester 0.
    words[0] = 64'hDEADBEEF_00000001;
    load_words();
    bus.req = 4'b0001;
    tick();
    check("t1_write_busy",  64'(bus.busy), 64'd1);
    check("t1_write_data",  bus.data_out, 64'd0);
    check("t1_write_valid", 64'(bus.valid), 64'd0);
    check("t1_write_ack",   64'(bus.ack), 64'd0);
    tick();
    check("t1_ack",   64'(bus.ack), 64'b0001);
    check("t1_data",  bus.data_out, 64'hDEADBEEF_00000001);
    check("t1_owner", 64'(bus.owner), 64'd0);
    check("t1_valid", 64'(bus.valid), 64'd1);
    check("t1_busy",  64'(bus.busy), 64'd1);
    bus.req = '0;
    tick();
    check("t1_ack_drop", 64'(bus.ack), 64'd0);
    check("t1_idle",     64'(bus.busy), 64'd0);

    // Round robin from rr_ptr=0 with all four requesting continuously.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) words[i] = {32'hA5A50000 + 32'(i), 32'h0F0F0F00 + 32'(i)};
    load_words();
    bus.req = 4'b1111;
    last_cyc = -1;
    for (int g = 0; g < 5; g++) begin
      expect_grant($sformatf("rr%0d", g), order[g], words[order[g]], this_cyc);
      if (g > 0 && this_cyc >= 0 && last_cyc >= 0)
        check($sformatf("rr%0d_gap", g), 64'(this_cyc - last_cyc), 64'd3);
      last_cyc = this_cyc;
    end

    // Pointer skip: grant to 1, then req=1001 goes to 3 then 0.
    bus.req = 4'b0010;
    expect_grant("skip_g1", 1, words[1], this_cyc);
    bus.req = 4'b1001;
    expect_grant("skip_g3", 3, words[3], this_cyc);
    expect_grant("skip_g0", 0, words[0], this_cyc);

    // Request 2 withdrawn during WRITE still completes.
    words[2] = 64'h2222_3333_4444_5555;
    load_words();
    bus.req = 4'b0100;
    tick();
    tick();
    check("wd_in_write", 64'(bus.busy), 64'd1);
    bus.req = '0;
    tick();
    check("wd_ack",  64'(bus.ack), 64'b0100);
    check("wd_data", bus.data_out, 64'h2222_3333_4444_5555);

    // Asynchronous reset in the middle of a WRITE for requester 3.
    words[3] = 64'h3333_0000_FFFF_0003;
    load_words();
    bus.req = 4'b1000;
    tick();
    tick();
    check("mr_in_write", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    bus.req = '0;
    #1;
    check("mr_data",  bus.data_out, 64'd0);
    check("mr_valid", 64'(bus.valid), 64'd0);
    check("mr_owner", 64'(bus.owner), 64'd0);
    check("mr_busy",  64'(bus.busy), 64'd0);
    check("mr_ack",   64'(bus.ack), 64'd0);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      check($sformatf("mr_after%0d_ack", n), 64'(bus.ack), 64'd0);
      check($sformatf("mr_after%0d_data", n), bus.data_out, 64'd0);
    end

    // Idle hold after a write of 0123456789ABCDEF from requester 2.
    words[2] = 64'h0123456789ABCDEF;
    load_words();
    bus.req = 4'b0100;
    expect_grant("hold_g2", 2, 64'h0123456789ABCDEF, this_cyc);
    bus.req = '0;
    for (int n = 0; n < 10; n++) begin
      tick();
      check($sformatf("hold%0d_data", n), bus.data_out, 64'h0123456789ABCDEF);
      check($sformatf("hold%0d_owner", n), 64'(bus.owner), 64'd2);
      check($sformatf("hold%0d_valid", n), 64'(bus.valid), 64'd1);
      check($sformatf("hold%0d_busy", n), 64'(bus.busy), 64'd0);
      check($sformatf("hold%0d_ack", n), 64'(bus.ack), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter that shares one 64-bit holding register among several requesters. Each requester presents a request and a 64-bit word. The arbiter selects one requester at a time, loads its word into the shared register and returns a one-cycle acknowledge. It sits in front of the shared 64-bit register stage. Its output is the registered word, which the downstream datapath consumes.

## Interface
- NUM_REQ, 4, number of requesters; legal values 2..8.
- DATA_WIDTH, 64, width of each request word and of the held register.
- IDX_WIDTH, 2, width of a requester index; must equal ceil(log2(NUM_REQ)).

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately.
- req  input  NUM_REQ  request vector; bit i held high by requester i until it sees ack[i].
- req_data  input  NUM_REQ*DATA_WIDTH  packed words; word i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  output  NUM_REQ  one-hot, one-cycle acknowledge; ack[i] means requester i's word has been written.
- data_out  output  DATA_WIDTH  shared held register.
- owner  output  IDX_WIDTH  index of the requester that last wrote data_out.
- valid  output  1  high once data_out has been written at least once since reset.
- busy  output  1  high whenever state is not IDLE.

## Operation
- Internal state:
  - FSM with states IDLE, WRITE and ACK.
  - grant_idx, a registered winner index, IDX_WIDTH bits.
  - rr_ptr, the round-robin pointer, IDX_WIDTH bits.
- Arbitration (evaluated in IDLE only): the winner is the first i with req[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- IDLE:
  - If any req bit is high: grant_idx <= winner; go to WRITE.
  - Otherwise stay in IDLE.
- WRITE:
  - data_out <= word grant_idx, sampled in this cycle.
  - owner <= grant_idx; valid <= 1.
  - ack[grant_idx] <= 1.
  - rr_ptr <= (grant_idx+1) mod NUM_REQ.
  - Go to ACK.
- ACK:
  - ack is high for this cycle only; the next state drives ack to 0.
  - req is ignored, with no arbitration; go to IDLE.
- Commit rule: once WRITE is entered the write is committed. If req[grant_idx] drops during WRITE, the write and ack still occur.
- Stability: data_out, owner and valid change only on the WRITE→ACK edge. Otherwise they hold.
- Requester contract: deassert req[i] (or change its data for a new request) on the edge after ack[i] is seen. A req still high in the following IDLE is treated as a new request.
- Reset (asynchronous, active-low, any state, including mid-WRITE):
  - state=IDLE, grant_idx=0, rr_ptr=0.
  - data_out=0, owner=0, valid=0, ack=0, busy=0.
  - Any pending write is discarded.
- Fairness: a continuously requesting requester is served within NUM_REQ grants.

## Timing
- Cycle 0 (IDLE): req sampled and winner latched.
- Cycle 1 (WRITE): busy=1; req_data of the winner sampled.
- Cycle 2 (ACK): data_out, owner and valid updated; ack[winner]=1; busy=1.
- Cycle 3 (IDLE): next arbitration.
- Latency is 2 edges from the IDLE cycle in which req is sampled to data_out/ack being visible.
- Peak throughput is one write per 3 cycles.
- ack is never high for more than 1 consecutive cycle, and never more than one bit at a time.
- busy is a decode of state, with no extra latency.

## Test plan
- Reset then single request:
  - Stimulus: reset low 3 cycles, release; req=4'b0001, word0=64'hDEADBEEF_00000001.
  - Required: data_out=64'h0 and valid=0 until the ACK cycle. In ACK (2 edges after req sampled): data_out=64'hDEADBEEF_00000001, ack=4'b0001, owner=0, valid=1.
- Round-robin with all four requesting continuously (each re-requests after its ack), starting from rr_ptr=0:
  - Required: ack grant order is 0,1,2,3,0, one grant every 3 cycles; data_out matches each winner's word.
- Pointer skip:
  - Stimulus: after a grant to 1, req=4'b1001.
  - Required: the next grant goes to 3 (search starts at 2); the grant after that goes to 0.
- Request withdrawn during WRITE:
  - Stimulus: req[2] asserted, then dropped in the WRITE cycle.
  - Required: data_out still takes word2, and ack=4'b0100 in the ACK cycle.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously during WRITE for requester 3.
  - Required: outputs go to 0/IDLE immediately with no clock edge. After release there is no ack and no data_out change until a new req.
- Idle hold:
  - Stimulus: req=0 for 10 cycles after a write of 64'h0123456789ABCDEF.
  - Required: data_out, owner and valid stay constant, with busy=0 and ack=0 throughout.
